// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, LSB first, one full-subtractor cell per clock.
// Start/busy/done handshake; d/bout/zero update only when an operation completes.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_d;
  logic [WIDTH-1:0] w_a, w_b, w_res, w_d;
  logic             r_br, r_bout, r_zero, r_busy, r_done;
  logic             w_br, w_bout, w_zero, w_busy, w_done;
  logic [CW-1:0]    r_cnt, w_cnt;

  // Full-subtractor cell on the current LSBs
  logic             w_diff, w_br_nxt, w_last;
  logic [WIDTH-1:0] w_res_shift;

  assign w_diff      = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_nxt    = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);
  assign w_res_shift = {w_diff, r_res[WIDTH-1:1]};
  assign w_last      = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_d     <= '0;
      r_br    <= 1'b0;
      r_bout  <= 1'b0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a;
      r_b     <= w_b;
      r_res   <= w_res;
      r_d     <= w_d;
      r_br    <= w_br;
      r_bout  <= w_bout;
      r_zero  <= w_zero;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a         = r_a;
    w_b         = r_b;
    w_res       = r_res;
    w_d         = r_d;
    w_br        = r_br;
    w_bout      = r_bout;
    w_zero      = r_zero;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_cnt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a         = a;
          w_b         = b;
          w_br        = bin;
          w_res       = '0;
          w_cnt       = '0;
          w_busy      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_a   = r_a >> 1;
        w_b   = r_b >> 1;
        w_br  = w_br_nxt;
        w_res = w_res_shift;
        w_cnt = r_cnt + CW'(1);
        // Final bit: publish result, borrow and zero flag together
        if (w_last) begin
          w_d         = w_res_shift;
          w_bout      = w_br_nxt;
          w_zero      = (w_res_shift == '0);
          w_done      = 1'b1;
          w_busy      = 1'b0;
          w_cnt       = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign d    = r_d;
  assign bout = r_bout;
  assign zero = r_zero;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed WIDTH=4 cases plus a
// back-to-back random run on a WIDTH=8 instance.
module tb_serial_subtractor;

  typedef struct packed {
    logic [7:0] d;
    logic       bout;
    logic       zero;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start4, bin4, bout4, zero4, busy4, done4;
  logic [3:0] a4, b4, d4;
  logic       start8, bin8, bout8, zero8, busy8, done8;
  logic [7:0] a8, b8, d8;

  exp_t q4[$];
  exp_t q8[$];
  int   errors;
  int   checks;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .d(d4), .bout(bout4), .zero(zero4), .busy(busy4), .done(done4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .d(d8), .bout(bout8), .zero(zero8), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: compare every done pulse against the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut4_unexpected_done: got d=%0d with no pending op at %0t", d4, $time);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("dut4_result", 32'({d4, bout4, zero4}), 32'({e.d[3:0], e.bout, e.zero}));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut8_unexpected_done: got d=%0d with no pending op at %0t", d8, $time);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("dut8_result", 32'({d8, bout8, zero8}), 32'({e.d, e.bout, e.zero}));
      end
    end
  end

  // Called at a negedge; holds start for one cycle and returns at the next negedge
  task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic bi,
                     input logic push, input logic [3:0] ed, input logic eb, input logic ez);
    exp_t e;
    start4 = 1'b1;
    a4     = a;
    b4     = b;
    bin4   = bi;
    if (push) begin
      e.d    = {4'd0, ed};
      e.bout = eb;
      e.zero = ez;
      q4.push_back(e);
    end
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait_done4();
    int n;
    n = 0;
    while (!done4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("dut4_done_timeout", 32'(done4), 32'd1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_dut4", 32'({d4, bout4, zero4, busy4, done4}), 32'd0);
    chk("reset_dut8", 32'({d8, bout8, zero8, busy8, done8}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 9-3: busy for four cycles, done on the fifth sample after start
    go4(4'd9, 4'd3, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("t1_busy_during", 32'({busy4, done4}), 32'b10);
      @(negedge clk);
    end
    chk("t1_done_pulse", 32'({busy4, done4}), 32'b01);
    @(negedge clk);
    chk("t1_done_clears", 32'(done4), 32'd0);

    go4(4'd3, 4'd9, 1'b0, 1'b1, 4'd10, 1'b1, 1'b0);
    wait_done4();
    @(negedge clk);
    go4(4'd0, 4'd0, 1'b1, 1'b1, 4'd15, 1'b1, 1'b0);
    wait_done4();
    @(negedge clk);

    // Zero result then check it holds through the next operation
    go4(4'd5, 4'd5, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    wait_done4();
    @(negedge clk);
    go4(4'd9, 4'd3, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("t3_hold_d_zero", 32'({d4, zero4}), 32'({4'd0, 1'b1}));
      @(negedge clk);
    end
    wait_done4();
    @(negedge clk);

    // Start while busy is ignored; start in done cycle is accepted
    go4(4'd7, 4'd2, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd1; b4 = 4'd1; bin4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    wait_done4();
    go4(4'd8, 4'd1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("t4_no_early_done", 32'(done4), 32'd0);
      @(negedge clk);
    end
    chk("t4_b2b_done", 32'(done4), 32'd1);
    @(negedge clk);

    // Reset mid-operation aborts without a done pulse
    go4(4'd12, 4'd4, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_async_reset", 32'({d4, bout4, zero4, busy4, done4}), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t5_no_done_in_reset", 32'({busy4, done4}), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    go4(4'd12, 4'd4, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0);
    wait_done4();
    @(negedge clk);
    chk("dut4_queue_drained", 32'(q4.size()), 32'd0);

    // WIDTH=8 random back-to-back: next start issued in each done cycle
    for (int i = 0; i < 2000; i++) begin
      exp_t       e;
      logic [8:0] full;
      int         n;
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      bin8 = 1'($urandom);
      if (i < 3) begin
        a8   = (i == 0) ? 8'd0 : ((i == 1) ? 8'd255 : 8'd128);
        b8   = (i == 0) ? 8'd255 : ((i == 1) ? 8'd0 : 8'd128);
        bin8 = (i != 1);
      end
      full   = {1'b0, a8} - {1'b0, b8} - 9'(bin8);
      e.d    = full[7:0];
      e.bout = full[8];
      e.zero = (full[7:0] == 8'd0);
      q8.push_back(e);
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      a8 = '0; b8 = '0; bin8 = 1'b0;
      n = 0;
      while (!done8 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!done8) begin
        chk("dut8_done_timeout", 32'(done8), 32'd1);
        break;
      end
    end
    @(negedge clk);
    @(negedge clk);
    chk("dut8_queue_drained", 32'(q8.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
